// File: rtl/pp_accum_pipe.sv
// pp_accum_pipe: two-stage pipelined accumulator of four partial products.
// Stage 1 holds a carry-save (sum, carry) pair of the aligned terms. Stage 2
// resolves that pair into out_data. Both stages use a valid/ready handshake.
// Optional approximate mode is compiled in with PP_ACCUM_APPROX_EN. When it is
// defined, apx_mode clears the low APX_K bits of lh/hl for that transaction.
// When it is not defined, apx_mode is accepted but ignored.
module pp_accum_pipe #(
  parameter int unsigned PP_W  = 8,
  parameter int unsigned APX_K = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PP_W-1:0]     ll,
  input  logic [PP_W-1:0]     lh,
  input  logic [PP_W-1:0]     hl,
  input  logic [PP_W-1:0]     hh,
  input  logic                apx_mode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*PP_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_cnt
);

  localparam int unsigned H  = PP_W / 2;
  localparam int unsigned W2 = 2 * PP_W;

  logic [PP_W-1:0] lh_m;
  logic [PP_W-1:0] hl_m;

`ifdef PP_ACCUM_APPROX_EN
  localparam logic [PP_W:0]   LOW_ONES = ((PP_W+1)'(1) << APX_K) - (PP_W+1)'(1);
  localparam logic [PP_W-1:0] KEEP     = ~LOW_ONES[PP_W-1:0];

  // Clear the low APX_K bits of the cross terms when apx_mode is set.
  always_comb begin
    lh_m = lh;
    hl_m = hl;
    if (apx_mode) begin
      lh_m = lh & KEEP;
      hl_m = hl & KEEP;
    end
  end
`else
  logic unused_apx;
  assign unused_apx = apx_mode | (APX_K > PP_W);
  assign lh_m = lh;
  assign hl_m = hl;
`endif

  logic [W2-1:0] t_ll, t_lh, t_hl, t_hh;
  logic [W2-1:0] csa_s0, csa_c0, csa_s, csa_c;

  // Align the four terms and compress them to a sum/carry pair. Two 3:2
  // compressors are used. Carries above bit W2-1 are discarded.
  always_comb begin
    t_ll   = {{PP_W{1'b0}}, ll};
    t_lh   = {{PP_W{1'b0}}, lh_m} << H;
    t_hl   = {{PP_W{1'b0}}, hl_m} << H;
    t_hh   = {hh, {PP_W{1'b0}}};
    csa_s0 = t_ll ^ t_lh ^ t_hl;
    csa_c0 = ((t_ll & t_lh) | (t_ll & t_hl) | (t_lh & t_hl)) << 1;
    csa_s  = csa_s0 ^ csa_c0 ^ t_hh;
    csa_c  = ((csa_s0 & csa_c0) | (csa_s0 & t_hh) | (csa_c0 & t_hh)) << 1;
  end

  logic          s1_valid;
  logic [W2-1:0] s1_sum;
  logic [W2-1:0] s1_carry;
  logic          s2_adv;
  logic          s1_adv;

  // Each stage advances when it is empty or when the stage after it drains.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  // Pipeline registers and the delivered-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_carry  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum   <= csa_s;
          s1_carry <= csa_c;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_sum + s1_carry;
        end
      end
      if (out_valid && out_ready) begin
        out_cnt <= out_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pp_accum_pipe.sv
// tb_pp_accum_pipe: randomized and directed checks of pp_accum_pipe.
// The reference model is a queue of in-flight results. Each result is
// computed arithmetically from the operands.
module tb_pp_accum_pipe;

  localparam int unsigned PP_W  = 8;
  localparam int unsigned APX_K = 4;
  localparam int unsigned H     = PP_W / 2;
`ifdef PP_ACCUM_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PP_W-1:0]     ll = '0, lh = '0, hl = '0, hh = '0;
  logic                apx_mode = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [2*PP_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [15:0]         out_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pp_accum_pipe #(.PP_W(PP_W), .APX_K(APX_K)) dut (
    .clk(clk), .rst(rst), .ll(ll), .lh(lh), .hl(hl), .hh(hh),
    .apx_mode(apx_mode), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference result: plain integer arithmetic, truncated to 2*PP_W bits.
  function automatic logic [2*PP_W-1:0] model(input logic [PP_W-1:0] a, b, c, d,
                                              input logic apx);
    longint unsigned lhv, hlv, s;
    lhv = 64'(b);
    hlv = 64'(c);
    if (apx && APPROX) begin
      lhv = (lhv >> APX_K) << APX_K;
      hlv = (hlv >> APX_K) << APX_K;
    end
    s = 64'(a) + (lhv << H) + (hlv << H) + (64'(d) << PP_W);
    return s[2*PP_W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2*PP_W-1:0] val;
    int                cap;
  } txn_t;

  txn_t q[$];

  // Model update and compare, once per cycle.
  // The compare runs at the falling edge, where inputs and outputs are stable.
  initial begin : compare
    int                k = 0;
    bit                p_rst = 1'b1;
    bit                p_acc = 1'b0;
    bit                p_xfer = 1'b0;
    logic [2*PP_W-1:0] p_val = '0;
    logic [15:0]       cnt_m = '0;
    bit                ev, er;
    forever begin
      @(negedge clk);
      k++;
      if (p_rst) begin
        q.delete();
        cnt_m = '0;
      end else begin
        if (p_xfer) begin
          void'(q.pop_front());
          cnt_m = cnt_m + 16'd1;
        end
        if (p_acc) q.push_back('{val: p_val, cap: k});
      end
      ev = (q.size() > 0) && (q[0].cap < k);
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) chk("out_data", 32'(out_data), 32'(q[0].val));
      else if (p_rst) chk("rst_out_data", 32'(out_data), 32'd0);
      chk("out_cnt", 32'(out_cnt), 32'(cnt_m));
      er = (q.size() < 2) || out_ready;
      if (!rst) chk("in_ready", 32'(in_ready), 32'(er));
      p_rst  = rst;
      p_acc  = in_valid && er;
      p_xfer = ev && out_ready;
      p_val  = model(ll, lh, hl, hh, apx_mode);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_in();
    ll = PP_W'($urandom);
    lh = PP_W'($urandom);
    hl = PP_W'($urandom);
    hh = PP_W'($urandom);
    apx_mode = 1'($urandom);
  endtask

  task automatic wait_accept(input string nm);
    for (int w = 0; w < 32; w++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        return;
      end
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: in_ready never rose within 32 cycles, expected accept", nm);
  endtask

  // Send one transaction into an idle pipeline.
  // Check the output two edges after acceptance against a hand-computed value.
  task automatic directed(input logic [PP_W-1:0] a, b, c, d, input logic apx,
                          input logic [2*PP_W-1:0] exp, input string nm);
    ll = a; lh = b; hl = c; hh = d; apx_mode = apx;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk(nm, 32'(out_data), 32'(exp));
    tick();
  endtask

  initial begin : stim
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    // Directed arithmetic cases: exact, approximate, and full carry-out.
    directed(8'h8F, 8'h84, 8'h82, 8'h78, 1'b0, 16'h88EF, "exact_abcd");
    directed(8'h8F, 8'h84, 8'h82, 8'h78, 1'b1,
             APPROX ? 16'h888F : 16'h88EF, "apx_abcd");
    directed(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h1FDF, "all_ones");
    directed(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, "all_zero");

    // Five-transaction burst with out_ready dropped from the third.
    reset_pulse();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_in();
      in_valid = 1'b1;
      if (i == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          tick();
        end
        out_ready = 1'b1;
      end
      wait_accept("burst_accept");
    end
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("burst_cnt", 32'(out_cnt), 32'd5);
    tick();

    // Reset while two transactions are in flight.
    reset_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      in_valid = 1'b1;
      wait_accept("flush_accept");
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(out_cnt), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
      tick();
    end

    // Random traffic with random back-pressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_in();
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Counter wrap: deliver 65535 results, then one more.
    reset_pulse();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      rand_in();
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("cnt_ffff", 32'(out_cnt), 32'h0000FFFF);
    tick();
    rand_in();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("cnt_wrap", 32'(out_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
